// File: rtl/wifi_tx_pkg.sv
// Shared constants and helpers for the 802.11a transmit bit path.
package wifi_tx_pkg;

  // Coded bits per OFDM symbol for each 802.11a modulation
  localparam int N_CBPS_BPSK  = 48;
  localparam int N_CBPS_QPSK  = 96;
  localparam int N_CBPS_16QAM = 192;
  localparam int N_CBPS_64QAM = 288;

  // Coded bits per subcarrier for each modulation
  localparam int N_BPSC_BPSK  = 1;
  localparam int N_BPSC_QPSK  = 2;
  localparam int N_BPSC_16QAM = 4;
  localparam int N_BPSC_64QAM = 6;

  localparam int ADDR_W  = $clog2(N_CBPS_64QAM);
  localparam int ARITH_W = 16;

  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_e;

  function automatic int intlv_s(input int n_bpsc);
    return (n_bpsc / 2 > 1) ? n_bpsc / 2 : 1;
  endfunction

  function automatic bit intlv_legal(input int n_cbps, input int n_bpsc);
    return (n_cbps == N_CBPS_BPSK  && n_bpsc == N_BPSC_BPSK)  ||
           (n_cbps == N_CBPS_QPSK  && n_bpsc == N_BPSC_QPSK)  ||
           (n_cbps == N_CBPS_16QAM && n_bpsc == N_BPSC_16QAM) ||
           (n_cbps == N_CBPS_64QAM && n_bpsc == N_BPSC_64QAM);
  endfunction

endpackage

// File: rtl/intlv_addr_gen.sv
// Combinational k -> j interleaver address map. The second (constellation)
// permutation is built only when INTLV_PERM2_EN is defined.
module intlv_addr_gen
  import wifi_tx_pkg::*;
#(
  parameter int N_CBPS = 48,
  parameter int N_BPSC = 1,
  parameter int CNT_W  = $clog2(N_CBPS)
) (
  input  logic [CNT_W-1:0] k,
  output logic [CNT_W-1:0] j
);

  if (!intlv_legal(N_CBPS, N_BPSC)) begin : g_illegal_cfg
    $error("intlv_addr_gen: unsupported N_CBPS/N_BPSC pair");
  end

  localparam logic [ARITH_W-1:0] COLS = ARITH_W'(N_CBPS / 16);

`ifdef INTLV_PERM2_EN
  localparam int S = intlv_s(N_BPSC);
  localparam logic [ARITH_W-1:0] SW = ARITH_W'(S);
  localparam logic [ARITH_W-1:0] NC = ARITH_W'(N_CBPS);
`endif

  logic [ARITH_W-1:0] k_w;
  logic [ARITH_W-1:0] i_w;

  always_comb begin
    k_w = ARITH_W'(k);
    // row/column transpose of a 16-row matrix
    i_w = COLS * ARITH_W'(k_w[3:0]) + (k_w >> 4);
`ifdef INTLV_PERM2_EN
    // rotate bits within each group of S so they alternate between MSB and LSB positions
    j = CNT_W'(SW * (i_w / SW) + ((i_w + NC - ((i_w << 4) / NC)) % SW));
`else
    j = CNT_W'(i_w);
`endif
  end

endmodule

// File: rtl/wifi_interleaver.sv
// 802.11a TX block interleaver, double-buffered at 1 bit/clk.
// Define INTLV_PERM2_EN to include the second permutation (needed for 16/64-QAM).
module wifi_interleaver
  import wifi_tx_pkg::*;
#(
  parameter int N_CBPS = 48,
  parameter int N_BPSC = 1
) (
  input  logic Clock,
  input  logic Reset,
  input  logic In_Valid,
  output logic In_Ready,
  input  logic In_Bit,
  output logic Out_Valid,
  input  logic Out_Ready,
  output logic Out_Bit,
  output logic Out_Last
);

  localparam int CNT_W = $clog2(N_CBPS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_CBPS - 1);

  logic [CNT_W-1:0] k_reg, k_next;
  logic [CNT_W-1:0] j_reg, j_next;
  logic             wsel_reg, wsel_next;
  logic             rsel_reg, rsel_next;
  logic             out_valid_reg, out_valid_next;
  logic             out_bit_reg, out_bit_next;
  logic             out_last_reg, out_last_next;

  logic [CNT_W-1:0] wr_addr;
  logic [CNT_W-1:0] rd_addr;
  logic [CNT_W-1:0] j_inc;
  logic [1:0]       rd_data;
  logic [1:0]       bank_full;
  logic             wr_en, wr_done;
  logic             rd_xfer, rd_done, rd_start;
  logic             other_ready, chain_bit;

  intlv_addr_gen #(
    .N_CBPS (N_CBPS),
    .N_BPSC (N_BPSC),
    .CNT_W  (CNT_W)
  ) u_addr_gen (
    .k (k_reg),
    .j (wr_addr)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      logic        mem [N_CBPS];
      bank_state_e state_reg;

      always_ff @(posedge Clock) begin
        if (wr_en && (wsel_reg == 1'(gi))) begin
          mem[wr_addr] <= In_Bit;
        end
      end

      always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
          state_reg <= BANK_EMPTY;
        end else if (wr_done && (wsel_reg == 1'(gi))) begin
          state_reg <= BANK_FULL;
        end else if (rd_done && (rsel_reg == 1'(gi))) begin
          state_reg <= BANK_EMPTY;
        end
      end

      assign rd_data[gi]   = mem[rd_addr];
      assign bank_full[gi] = (state_reg == BANK_FULL);
    end
  endgenerate

  assign In_Ready  = !bank_full[wsel_reg];
  assign wr_en     = In_Valid && In_Ready;
  assign wr_done   = wr_en && (k_reg == LAST_IDX);
  assign rd_xfer   = out_valid_reg && Out_Ready;
  assign rd_done   = rd_xfer && out_last_reg;
  assign rd_start  = !out_valid_reg && bank_full[rsel_reg];
  assign j_inc     = j_reg + 1'b1;
  assign rd_addr   = (rd_xfer && !rd_done) ? j_inc : '0;

  // The next bank may complete on the same edge as this bank drains; chaining
  // onto it then keeps Out_Valid continuous, forwarding In_Bit if it targets address 0.
  assign other_ready = bank_full[!rsel_reg] || (wr_done && (wsel_reg != rsel_reg));
  assign chain_bit   = (wr_done && (wr_addr == '0)) ? In_Bit : rd_data[!rsel_reg];

  always_comb begin
    k_next         = k_reg;
    wsel_next      = wsel_reg;
    j_next         = j_reg;
    rsel_next      = rsel_reg;
    out_valid_next = out_valid_reg;
    out_bit_next   = out_bit_reg;
    out_last_next  = out_last_reg;

    if (wr_en) begin
      if (wr_done) begin
        k_next    = '0;
        wsel_next = !wsel_reg;
      end else begin
        k_next = k_reg + 1'b1;
      end
    end

    if (rd_done) begin
      rsel_next      = !rsel_reg;
      j_next         = '0;
      out_valid_next = other_ready;
      out_bit_next   = other_ready ? chain_bit : 1'b0;
      out_last_next  = 1'b0;
    end else if (rd_xfer) begin
      j_next        = j_inc;
      out_bit_next  = rd_data[rsel_reg];
      out_last_next = (j_inc == LAST_IDX);
    end else if (rd_start) begin
      j_next         = '0;
      out_valid_next = 1'b1;
      out_bit_next   = rd_data[rsel_reg];
      out_last_next  = 1'b0;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      k_reg         <= '0;
      j_reg         <= '0;
      wsel_reg      <= 1'b0;
      rsel_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      out_bit_reg   <= 1'b0;
      out_last_reg  <= 1'b0;
    end else begin
      k_reg         <= k_next;
      j_reg         <= j_next;
      wsel_reg      <= wsel_next;
      rsel_reg      <= rsel_next;
      out_valid_reg <= out_valid_next;
      out_bit_reg   <= out_bit_next;
      out_last_reg  <= out_last_next;
    end
  end

  assign Out_Valid = out_valid_reg;
  assign Out_Bit   = out_bit_reg;
  assign Out_Last  = out_last_reg;

endmodule

// File: tb/tb_wifi_interleaver.sv
// Self-checking bench: a 48/1 instance for throughput, stall, reset and random
// throttling, plus a 192/4 instance for the constellation permutation.
module tb_wifi_interleaver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic a_rst_n, a_in_valid, a_in_ready, a_in_bit, a_out_valid, a_out_ready, a_out_bit, a_out_last;
  logic b_rst_n, b_in_valid, b_in_ready, b_in_bit, b_out_valid, b_out_ready, b_out_bit, b_out_last;

  int checks = 0;
  int errors = 0;
  int a_accepted = 0;
  int a_sym_total = 0;

  logic [47:0]  a_exp_q[$], a_got_q[$], a_last_q[$];
  logic [191:0] b_exp_q[$], b_got_q[$], b_last_q[$];

  localparam logic [47:0]  LAST48  = 48'h8000_0000_0000;
  localparam logic [191:0] LAST192 = {1'b1, 191'b0};

  wifi_interleaver #(.N_CBPS(48), .N_BPSC(1)) dut_a (
    .Clock(clk), .Reset(a_rst_n), .In_Valid(a_in_valid), .In_Ready(a_in_ready), .In_Bit(a_in_bit),
    .Out_Valid(a_out_valid), .Out_Ready(a_out_ready), .Out_Bit(a_out_bit), .Out_Last(a_out_last)
  );

  wifi_interleaver #(.N_CBPS(192), .N_BPSC(4)) dut_b (
    .Clock(clk), .Reset(b_rst_n), .In_Valid(b_in_valid), .In_Ready(b_in_ready), .In_Bit(b_in_bit),
    .Out_Valid(b_out_valid), .Out_Ready(b_out_ready), .Out_Bit(b_out_bit), .Out_Last(b_out_last)
  );

  task automatic check(input string tag, input logic [191:0] observed, input logic [191:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference: output position of coded bit k, straight from the 802.11a rules
  function automatic int ref_index(input int n, input int bpsc, input int k);
    int i;
`ifdef INTLV_PERM2_EN
    int s;
`endif
    i = (n / 16) * (k % 16) + k / 16;
`ifdef INTLV_PERM2_EN
    s = (bpsc / 2 > 1) ? bpsc / 2 : 1;
    return s * (i / s) + (i + n - (16 * i) / n) % s;
`else
    return (bpsc > 0) ? i : i;
`endif
  endfunction

  function automatic logic [191:0] ref_symbol(input logic [191:0] bits, input int n, input int bpsc);
    logic [191:0] o;
    o = '0;
    for (int k = 0; k < n; k++) o[ref_index(n, bpsc, k)] = bits[k];
    return o;
  endfunction

  function automatic logic [47:0] ref48(input logic [47:0] bits);
    logic [191:0] t;
    t = ref_symbol({144'b0, bits}, 48, 1);
    return t[47:0];
  endfunction

  function automatic logic [47:0] rand48();
    return 48'({$urandom(), $urandom()});
  endfunction

  task automatic monitor_a();
    logic [47:0] bits, lasts;
    logic [1:0]  held;
    logic        stall;
    int          cnt;
    bits = '0; lasts = '0; held = '0; stall = 1'b0; cnt = 0;
    forever begin
      @(negedge clk);
      if (!a_rst_n) begin
        cnt = 0;
        stall = 1'b0;
      end else begin
        if (stall) check("a_hold_stable", {a_out_valid, a_out_last, a_out_bit}, {1'b1, held});
        stall = a_out_valid && !a_out_ready;
        held = {a_out_last, a_out_bit};
        if (a_out_valid && a_out_ready) begin
          bits[cnt] = a_out_bit;
          lasts[cnt] = a_out_last;
          cnt++;
          if (cnt == 48) begin
            a_got_q.push_back(bits);
            a_last_q.push_back(lasts);
            a_sym_total++;
            cnt = 0;
          end
        end
      end
    end
  endtask

  task automatic monitor_b();
    logic [191:0] bits, lasts;
    int cnt;
    bits = '0; lasts = '0; cnt = 0;
    forever begin
      @(negedge clk);
      if (!b_rst_n) begin
        cnt = 0;
      end else if (b_out_valid && b_out_ready) begin
        bits[cnt] = b_out_bit;
        lasts[cnt] = b_out_last;
        cnt++;
        if (cnt == 192) begin
          b_got_q.push_back(bits);
          b_last_q.push_back(lasts);
          cnt = 0;
        end
      end
    end
  endtask

  // Called at posedge+1; sends the first nbits of a symbol with In_Valid asserted pct% of cycles
  task automatic send_a(input logic [47:0] bits, input int pct, input int nbits);
    int k, guard;
    k = 0; guard = 0;
    while (k < nbits && guard < 4000) begin
      a_in_valid = ($urandom_range(0, 99) < pct);
      a_in_bit = bits[k];
      @(negedge clk);
      if (a_in_valid && a_in_ready) begin
        k++;
        a_accepted++;
      end
      @(posedge clk); #1;
      guard++;
    end
    a_in_valid = 1'b0;
    check("a_send_accepted", k, nbits);
  endtask

  task automatic send_b(input logic [191:0] bits);
    int k, guard;
    k = 0; guard = 0;
    while (k < 192 && guard < 4000) begin
      b_in_valid = 1'b1;
      b_in_bit = bits[k];
      @(negedge clk);
      if (b_in_ready) k++;
      @(posedge clk); #1;
      guard++;
    end
    b_in_valid = 1'b0;
    check("b_send_accepted", k, 192);
  endtask

  task automatic drive_ready_a(input int pct, input int target);
    int guard;
    guard = 0;
    while (a_sym_total < target && guard < 40000) begin
      a_out_ready = ($urandom_range(0, 99) < pct);
      @(posedge clk); #1;
      guard++;
    end
    a_out_ready = 1'b1;
    check("a_ready_budget", a_sym_total, target);
  endtask

  task automatic check_syms_a(input int n, input string tag);
    int g;
    g = 0;
    while (a_got_q.size() < n && g < 5000) begin
      @(posedge clk);
      g++;
    end
    check({tag, "_count"}, a_got_q.size(), n);
    for (int s = 0; s < n && a_got_q.size() > 0 && a_exp_q.size() > 0; s++) begin
      check({tag, "_data"}, a_got_q.pop_front(), a_exp_q.pop_front());
      check({tag, "_last"}, a_last_q.pop_front(), LAST48);
    end
    a_got_q.delete(); a_last_q.delete(); a_exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_syms_b(input int n, input string tag);
    int g;
    g = 0;
    while (b_got_q.size() < n && g < 5000) begin
      @(posedge clk);
      g++;
    end
    check({tag, "_count"}, b_got_q.size(), n);
    for (int s = 0; s < n && b_got_q.size() > 0 && b_exp_q.size() > 0; s++) begin
      check({tag, "_data"}, b_got_q.pop_front(), b_exp_q.pop_front());
      check({tag, "_last"}, b_last_q.pop_front(), LAST192);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [47:0]  r;
    logic [191:0] rb, eb;
    int gaps, g, target;

    a_rst_n = 1'b0; a_in_valid = 1'b0; a_in_bit = 1'b0; a_out_ready = 1'b0;
    b_rst_n = 1'b0; b_in_valid = 1'b0; b_in_bit = 1'b0; b_out_ready = 1'b1;
    fork
      monitor_a();
      monitor_b();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("a_rst_out_valid", a_out_valid, 1'b0);
    check("a_rst_out_bit", a_out_bit, 1'b0);
    check("a_rst_out_last", a_out_last, 1'b0);
    check("a_rst_in_ready", a_in_ready, 1'b1);
    check("b_rst_in_ready", b_in_ready, 1'b1);
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    @(posedge clk); #1;
    check("a_idle_out_valid", a_out_valid, 1'b0);

    // One-hot k=1 lands at j=3; k=16 and k=32 land at j=1 and j=2
    a_out_ready = 1'b1;
    a_exp_q.push_back(48'h8);
    send_a(48'h2, 100, 48);
    check_syms_a(1, "a_onehot_k1");
    a_exp_q.push_back(48'h6);
    send_a(48'h0001_0001_0000, 100, 48);
    check_syms_a(1, "a_onehot_k16_k32");

    // Three symbols back to back: Out_Valid must stay high for all 144 bits
    gaps = 0;
    fork
      begin
        for (int s = 0; s < 3; s++) begin
          r = rand48();
          a_exp_q.push_back(ref48(r));
          send_a(r, 100, 48);
        end
      end
      begin
        g = 0;
        while (!a_out_valid && g < 500) begin
          @(negedge clk);
          g++;
        end
        for (int c = 0; c < 144; c++) begin
          if (!a_out_valid) gaps++;
          @(negedge clk);
        end
      end
    join
    check("a_b2b_valid_gaps", gaps, 0);
    check_syms_a(3, "a_b2b");

    // Downstream stalled: exactly two symbols are absorbed, then nothing lost
    a_out_ready = 1'b0;
    a_accepted = 0;
    fork
      begin
        for (int s = 0; s < 3; s++) begin
          r = rand48();
          a_exp_q.push_back(ref48(r));
          send_a(r, 100, 48);
        end
      end
      begin
        repeat (120) @(negedge clk);
        check("a_stall_accepted", a_accepted, 96);
        check("a_stall_in_ready", a_in_ready, 1'b0);
        @(posedge clk); #1;
        a_out_ready = 1'b1;
      end
    join
    check_syms_a(3, "a_stall");

    // Reset in the middle of a symbol while output is pending
    a_out_ready = 1'b0;
    r = rand48() | 48'h1;
    send_a(r, 100, 48);
    repeat (2) @(posedge clk);
    #1;
    check("a_pre_rst_valid", a_out_valid, 1'b1);
    check("a_pre_rst_bit", a_out_bit, 1'b1);
    send_a(rand48(), 100, 20);
    a_rst_n = 1'b0;
    #1;
    check("a_midrst_out_valid", a_out_valid, 1'b0);
    check("a_midrst_out_bit", a_out_bit, 1'b0);
    check("a_midrst_out_last", a_out_last, 1'b0);
    check("a_midrst_in_ready", a_in_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    a_rst_n = 1'b1;
    a_got_q.delete(); a_last_q.delete(); a_exp_q.delete();
    a_out_ready = 1'b1;
    r = rand48();
    a_exp_q.push_back(ref48(r));
    send_a(r, 100, 48);
    check_syms_a(1, "a_post_rst");

    // 100 symbols with ~50% throttling on both sides
    target = a_sym_total + 100;
    fork
      begin
        for (int s = 0; s < 100; s++) begin
          r = rand48();
          a_exp_q.push_back(ref48(r));
          send_a(r, 50, 48);
        end
      end
      drive_ready_a(50, target);
    join
    check_syms_a(100, "a_random");

    // 16-QAM geometry: one-hot k=1, then a random symbol
`ifdef INTLV_PERM2_EN
    eb = 192'h2000;
`else
    eb = 192'h1000;
`endif
    b_exp_q.push_back(eb);
    send_b(192'h2);
    rb = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    b_exp_q.push_back(ref_symbol(rb, 192, 4));
    send_b(rb);
    check_syms_b(2, "b_16qam");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
